spi_osd_master: RTL and testbench

- SPI master that drives the write-addressed SPI protocol consumed by the OSD text-window receiver.
- Lets on-chip logic (CPU bridge, boot ROM sequencer) write tile map bytes (0xFDxxxxxx, +0x10000 inverted) and the enable byte (0xFExxxxxx) without an external MCU.
- One transaction = command byte, 32-bit address MSB first, then N>=1 data bytes streamed over a valid/ready byte interface.
- SPI mode 0, MSB first.

---
 rtl/spi_osd_master.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_osd_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_osd_master.sv
// spi_osd_master: SPI mode-0 master for the OSD text-window receiver.
// Frame on one chip-select window:
//   command byte, then C_ADDR_BITS address bits (MSB first),
//   then N>=1 data bytes taken from a valid/ready byte interface.
// Optional feature macro: SPI_OSD_MASTER_READ_EN.
//   Adds the i_rd and i_miso inputs and the o_rdata and o_rvalid outputs.
//   With i_rd=1 the command byte is 0x01.
module spi_osd_master #(
  parameter int C_DIV       = 2,   // SCLK half-period in clk cycles
  parameter int C_ADDR_BITS = 32,  // address width, multiple of 8
  parameter int C_GAP       = 4    // minimum clocks CSN stays high afterwards
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [C_ADDR_BITS-1:0] i_addr,
  input  logic [7:0]             i_wdata,
  input  logic                   i_valid,
  input  logic                   i_last,
`ifdef SPI_OSD_MASTER_READ_EN
  input  logic                   i_rd,
  input  logic                   i_miso,
  output logic [7:0]             o_rdata,
  output logic                   o_rvalid,
`endif
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_csn,
  output logic                   o_sclk,
  output logic                   o_mosi
);

  localparam int DIV_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam int GAP_W = (C_GAP > 1) ? $clog2(C_GAP) : 1;
  localparam int BIT_W = $clog2(C_ADDR_BITS + 1);
  localparam int SR_W  = C_ADDR_BITS + 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_FETCH,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  // Command+address are loaded together and shifted as one stream.
  // Data bytes are loaded into the top byte.
  // MOSI is always the MSB.
  logic [SR_W-1:0]  sreg_q, sreg_d;
  logic             sclk_q, sclk_d;
  logic             csn_q, csn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_q, last_d;

  logic             bit_tick;
  logic             last_bit;
  logic [7:0]       cmd_byte;

`ifdef SPI_OSD_MASTER_READ_EN
  assign cmd_byte = i_rd ? 8'h01 : 8'h00;
`else
  assign cmd_byte = 8'h00;
`endif

  // End of one SCLK half-period
  assign bit_tick = (div_cnt_q == DIV_W'(C_DIV - 1));

  // Final bit of the current shift phase
  always_comb begin
    last_bit = 1'b0;
    unique case (state_q)
      S_CMD:   last_bit = (bit_cnt_q == BIT_W'(7));
      S_ADDR:  last_bit = (bit_cnt_q == BIT_W'(C_ADDR_BITS - 1));
      S_DATA:  last_bit = (bit_cnt_q == BIT_W'(7));
      default: last_bit = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the transaction FSM and bit engine
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sreg_d    = sreg_q;
    sclk_d    = sclk_q;
    csn_d     = csn_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    last_d    = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_CMD;
          busy_d    = 1'b1;
          csn_d     = 1'b0;
          sclk_d    = 1'b0;
          sreg_d    = {cmd_byte, i_addr};
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      S_CMD, S_ADDR, S_DATA: begin
        if (bit_tick) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (last_bit) begin
              bit_cnt_d = '0;
              unique case (state_q)
                S_CMD: begin
                  // The address MSB follows the command without a pause.
                  state_d = S_ADDR;
                  sreg_d  = sreg_q << 1;
                end
                S_ADDR:  state_d = S_FETCH;
                default: state_d = last_q ? S_HOLD : S_FETCH;
              endcase
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              sreg_d    = sreg_q << 1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_FETCH: begin
        // SCLK parked low and MOSI keeps its last bit until a byte arrives.
        if (i_valid) begin
          state_d   = S_DATA;
          sreg_d    = {i_wdata, C_ADDR_BITS'(0)};
          last_d    = i_last;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      S_HOLD: begin
        if (bit_tick) begin
          div_cnt_d = '0;
          gap_cnt_d = '0;
          csn_d     = 1'b1;
          done_d    = 1'b1;
          sreg_d    = '0;
          state_d   = S_GAP;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_W'(C_GAP - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction on the next edge
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sreg_q    <= '0;
      sclk_q    <= 1'b0;
      csn_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sreg_q    <= sreg_d;
      sclk_q    <= sclk_d;
      csn_q     <= csn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      last_q    <= last_d;
    end
  end

`ifdef SPI_OSD_MASTER_READ_EN
  logic [6:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       sample_en;

  // MISO is sampled on the clk edge that raises SCLK during a data byte.
  assign sample_en = (state_q == S_DATA) && bit_tick && !sclk_q;

  // MISO capture into the receive shifter
  always_comb begin
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (sample_en) begin
      rx_d = {rx_q[5:0], i_miso};
      if (bit_cnt_q == BIT_W'(7)) begin
        rdata_d  = {rx_q, i_miso};
        rvalid_d = 1'b1;
      end
    end
  end

  // Read data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
`endif

  assign o_ready = (state_q == S_FETCH);
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_csn   = csn_q;
  assign o_sclk  = sclk_q;
  assign o_mosi  = sreg_q[SR_W-1];

endmodule

// File: tb/tb_spi_osd_master.sv
// tb_spi_osd_master: table-driven, hand-written and random transactions.
// Each transaction's decoded SPI traffic is compared against a frame model:
//   expected frame = command byte, address bytes MSB first, then the data bytes.
// Two DUTs are used: C_DIV=2 (sel=0) and C_DIV=1 (sel=1).
module tb_spi_osd_master;
  localparam int AB  = 32;
  localparam int GAP = 4;

  typedef struct {
    logic [31:0]     addr;
    int              n;
    logic [3:0][7:0] d;
    int              stall_idx;
    int              stall_len;
    bit              sel;
    bit              extra;
    int              exp_rises;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_addr = '0;
  logic [7:0]  i_wdata = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  bit          sel = 1'b0;

  logic ready0, busy0, done0, csn0, sclk0, mosi0;
  logic ready1, busy1, done1, csn1, sclk1, mosi1;
  logic m_ready, m_busy, m_done, m_csn, m_sclk, m_mosi;

`ifdef SPI_OSD_MASTER_READ_EN
  logic       tb_rd = 1'b0;
  logic       tb_miso = 1'b0;
  logic [7:0] rdata0, rdata1, m_rdata;
  logic       rvalid0, rvalid1, m_rvalid;
  logic [7:0] miso_pat = 8'hA5;
  int         rv_cnt = 0, rv_bad = 0;
  assign m_rdata  = sel ? rdata1 : rdata0;
  assign m_rvalid = sel ? rvalid1 : rvalid0;
`endif

  spi_osd_master #(.C_DIV(2), .C_ADDR_BITS(AB), .C_GAP(GAP)) u_dut0 (
    .clk(clk), .reset(reset), .i_start(i_start & ~sel), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_valid(i_valid & ~sel), .i_last(i_last),
`ifdef SPI_OSD_MASTER_READ_EN
    .i_rd(tb_rd), .i_miso(tb_miso), .o_rdata(rdata0), .o_rvalid(rvalid0),
`endif
    .o_ready(ready0), .o_busy(busy0), .o_done(done0),
    .o_csn(csn0), .o_sclk(sclk0), .o_mosi(mosi0)
  );

  spi_osd_master #(.C_DIV(1), .C_ADDR_BITS(AB), .C_GAP(GAP)) u_dut1 (
    .clk(clk), .reset(reset), .i_start(i_start & sel), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_valid(i_valid & sel), .i_last(i_last),
`ifdef SPI_OSD_MASTER_READ_EN
    .i_rd(tb_rd), .i_miso(tb_miso), .o_rdata(rdata1), .o_rvalid(rvalid1),
`endif
    .o_ready(ready1), .o_busy(busy1), .o_done(done1),
    .o_csn(csn1), .o_sclk(sclk1), .o_mosi(mosi1)
  );

  assign m_ready = sel ? ready1 : ready0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_csn   = sel ? csn1   : csn0;
  assign m_sclk  = sel ? sclk1  : sclk0;
  assign m_mosi  = sel ? mosi1  : mosi0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: samples on the falling clk edge, away from the active edge
  int   cyc = 0;
  bit   rx_bits[$];
  int   rise_cyc[$];
  int   csn_falls = 0, done_cnt = 0, ready_pulses = 0, mosi_hi_chg = 0, rise_out_cs = 0;
  int   csn_fall_cyc = 0, csn_rise_cyc = 0, busy_fall_cyc = 0;
  int   miso_base = 0;
  logic p_sclk = 1'b0, p_mosi = 1'b0, p_csn = 1'b1, p_busy = 1'b0, p_ready = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (m_sclk && !p_sclk) begin
      if (!m_csn) rx_bits.push_back(m_mosi);
      else rise_out_cs++;
      rise_cyc.push_back(cyc);
    end
    if (m_sclk && (m_mosi !== p_mosi)) mosi_hi_chg++;
    if (!m_csn && p_csn) begin csn_falls++; csn_fall_cyc = cyc; end
    if (m_csn && !p_csn) csn_rise_cyc = cyc;
    if (!m_busy && p_busy) busy_fall_cyc = cyc;
    if (m_done) done_cnt++;
    if (m_ready && !p_ready) ready_pulses++;
`ifdef SPI_OSD_MASTER_READ_EN
    // Slave model: returns miso_pat MSB first for every data byte.
    if (rise_cyc.size() - miso_base >= 8 + AB)
      tb_miso = miso_pat[7 - ((rise_cyc.size() - miso_base - 8 - AB) % 8)];
    else
      tb_miso = 1'b0;
    if (m_rvalid) begin
      rv_cnt++;
      if (m_rdata !== miso_pat) rv_bad++;
    end
`endif
    p_sclk  = m_sclk;
    p_mosi  = m_mosi;
    p_csn   = m_csn;
    p_busy  = m_busy;
    p_ready = m_ready;
  end

  logic [7:0] exp_q[$];

  // Present one byte and hold it until the master takes it
  task automatic send_byte(input logic [7:0] b, input bit last);
    int t = 0;
    i_valid = 1'b1;
    i_wdata = b;
    i_last  = last;
    while (!m_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", m_ready, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_wdata = 8'($urandom);
  endtask

  task automatic run_txn(input logic [31:0] addr, input int n, input logic [3:0][7:0] d,
                         input int stall_idx, input int stall_len, input bit extra,
                         input int exp_rises, input bit rd);
    int   b_bits, b_rise, b_falls, b_done, b_ready, b_hichg, b_out, t, viol, cdiv;
    logic mosi_hold;
    logic [7:0] g;
    repeat (2) @(negedge clk);
    cdiv    = sel ? 1 : 2;
    b_bits  = rx_bits.size();
    b_rise  = rise_cyc.size();
    b_falls = csn_falls;
    b_done  = done_cnt;
    b_ready = ready_pulses;
    b_hichg = mosi_hi_chg;
    b_out   = rise_out_cs;
    miso_base = b_rise;
`ifdef SPI_OSD_MASTER_READ_EN
    tb_rd = rd;
`endif
    // Frame model
    exp_q = {};
    exp_q.push_back(rd ? 8'h01 : 8'h00);
    for (int i = AB / 8 - 1; i >= 0; i--) exp_q.push_back(addr[8*i +: 8]);
    for (int k = 0; k < n; k++) exp_q.push_back(d[k]);

    i_addr  = addr;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == stall_idx && stall_len > 0) begin
        t = 0;
        while (!m_ready && t < 2000) begin @(negedge clk); t++; end
        mosi_hold = m_mosi;
        viol = 0;
        repeat (stall_len) begin
          if (m_sclk !== 1'b0 || m_csn !== 1'b0 || m_mosi !== mosi_hold) viol++;
          @(negedge clk);
        end
        check("stall_quiet", viol, 0);
      end
      send_byte(d[k], k == n - 1);
      if (extra && k == 0) begin
        i_addr  = ~addr;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
    end
    t = 0;
    while (m_busy && t < 4000) begin @(negedge clk); t++; end
    check("busy_end", m_busy, 1'b0);
    repeat (extra ? 30 : 3) @(negedge clk);

    check("rises", rise_cyc.size() - b_rise, exp_rises);
    check("rises_model", rise_cyc.size() - b_rise, 8 * exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 8'h00;
      if (b_bits + 8 * i + 7 < rx_bits.size())
        for (int j = 0; j < 8; j++) g = {g[6:0], rx_bits[b_bits + 8 * i + j]};
      check($sformatf("mosi_byte%0d", i), g, exp_q[i]);
    end
    check("cs_windows", csn_falls - b_falls, 1);
    check("rise_outside_cs", rise_out_cs - b_out, 0);
    check("done_pulses", done_cnt - b_done, 1);
    check("ready_pulses", ready_pulses - b_ready, n);
    check("mosi_chg_sclk_hi", mosi_hi_chg - b_hichg, 0);
    check("busy_gap", busy_fall_cyc - csn_rise_cyc, GAP);
    if (rise_cyc.size() - b_rise >= 2) begin
      check("first_rise_lag", rise_cyc[b_rise] - csn_fall_cyc, cdiv);
      check("bit_period", rise_cyc[b_rise + 1] - rise_cyc[b_rise], 2 * cdiv);
    end
  endtask

  vec_t vecs[4];

  initial begin
    int b_rise, b_done, t;
    vecs[0] = '{32'hFE000000, 1, {8'h00, 8'h00, 8'h00, 8'h01}, -1, 0, 1'b0, 1'b0, 48};
    vecs[1] = '{32'hFD010000, 3, {8'h00, 8'h43, 8'h42, 8'h41}, -1, 0, 1'b0, 1'b0, 64};
    vecs[2] = '{32'hFD010000, 3, {8'h00, 8'h43, 8'h42, 8'h41}, 1, 50, 1'b0, 1'b0, 64};
    vecs[3] = '{32'h12345678, 2, {8'h00, 8'h00, 8'h55, 8'hAA}, -1, 0, 1'b1, 1'b1, 56};

    repeat (3) @(negedge clk);
    check("rst_csn", csn0, 1'b1);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_mosi", mosi0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", ready0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_csn_div1", csn1, 1'b1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      run_txn(vecs[i].addr, vecs[i].n, vecs[i].d, vecs[i].stall_idx, vecs[i].stall_len,
              vecs[i].extra, vecs[i].exp_rises, 1'b0);
    end

    // Reset after the 10th SCLK rising edge
    sel = 1'b0;
    repeat (2) @(negedge clk);
    b_rise = rise_cyc.size();
    b_done = done_cnt;
    i_addr = 32'hFD000010;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    t = 0;
    while (rise_cyc.size() - b_rise < 10 && t < 1000) begin @(negedge clk); t++; end
    check("reset_wait", rise_cyc.size() - b_rise, 10);
    reset = 1'b1;
    @(negedge clk);
    check("abort_csn", m_csn, 1'b1);
    check("abort_sclk", m_sclk, 1'b0);
    check("abort_busy", m_busy, 1'b0);
    check("abort_ready", m_ready, 1'b0);
    check("abort_done", m_done, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - b_done, 0);
    check("abort_idle_csn", m_csn, 1'b1);
    run_txn(32'hFD000010, 2, {8'h00, 8'h00, 8'h5A, 8'h3C}, -1, 0, 1'b0, 56, 1'b0);

    // Random transactions on both dividers
    for (int r = 0; r < 8; r++) begin
      logic [31:0] ra;
      logic [3:0][7:0] rdat;
      int rn;
      ra   = $urandom;
      rdat = $urandom;
      rn   = $urandom_range(1, 4);
      sel  = 1'($urandom_range(0, 1));
      run_txn(ra, rn, rdat, $urandom_range(0, rn - 1), $urandom_range(0, 12), 1'b0,
              8 + AB + 8 * rn, 1'b0);
    end

`ifdef SPI_OSD_MASTER_READ_EN
    begin
      int b_rv, b_bad;
      sel   = 1'b0;
      b_rv  = rv_cnt;
      b_bad = rv_bad;
      run_txn(32'hFD000000, 2, {8'h00, 8'h00, 8'h00, 8'h00}, -1, 0, 1'b0, 56, 1'b1);
      check("rvalid_count", rv_cnt - b_rv, 2);
      check("rdata_bad", rv_bad - b_bad, 0);
      tb_rd = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
